// File: rtl/package_dispatcher_pkg.sv
// Shared definitions for the packing-stage dispatcher: product codes,
// source count and the dispatch FSM state type.
package package_dispatcher_pkg;

    localparam int NUM_SRC = 5;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ALG_BAJO = 3'd1;
    localparam logic [2:0] CODE_POL_BAJO = 3'd2;
    localparam logic [2:0] CODE_ACR_BAJO = 3'd3;
    localparam logic [2:0] CODE_ALG_ALTO = 3'd4;
    localparam logic [2:0] CODE_ACR_ALTO = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        OFFER = 2'd2
    } state_t;

    // Counter index 0..4 maps onto product code 1..5.
    function automatic logic [2:0] src_to_code(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/package_dispatcher_code_fifo.sv
// Product-code queue: synchronous push/pop on a circular buffer with an
// occupancy output. Push when full and pop when empty are ignored.
module code_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [2:0]    i_data,
    input  logic          i_pop,
    output logic [2:0]    o_data,
    output logic [LW-1:0] o_level
);

    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && (r_level != LW'(DEPTH));
    assign w_do_pop  = i_pop  && (r_level != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the level untouched.
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/package_dispatcher.sv
// Packing dispatcher: round-robin grant of counter full flags into a code
// queue, then a timed pack cycle and a valid/ready offer per box.
module package_dispatcher
    import package_dispatcher_pkg::*;
#(
    parameter  int FIFO_DEPTH  = 4,
    parameter  int PACK_CYCLES = 8,
    parameter  int BOX_W       = 8,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       co,
    output logic [4:0]       co_ack,
    output logic             packing,
    output logic             disp_valid,
    output logic [2:0]       disp_code,
    input  logic             disp_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [BOX_W-1:0] box_cnt
);

    localparam int CNT_W = (PACK_CYCLES > 1) ? $clog2(PACK_CYCLES) : 1;

    logic [2:0]       r_ptr;
    logic [4:0]       r_mask_a;
    logic [4:0]       r_mask_b;
    logic [4:0]       r_ack;
    logic [4:0]       w_elig;
    logic             w_not_full;
    logic             w_grant_vld;
    logic [2:0]       w_grant_idx;
    logic [4:0]       w_grant_oh;
    logic [LVL_W-1:0] w_level;
    logic [2:0]       w_head;
    logic             w_pop;
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_code;
    logic [BOX_W-1:0] r_box_cnt;

    function automatic logic [BOX_W-1:0] sat_inc(input logic [BOX_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A source stays masked for two cycles after its grant, covering the
    // counter's clear latency so the same full flag is never captured twice.
    assign w_not_full = (w_level < LVL_W'(FIFO_DEPTH));
    assign w_elig     = co & ~(r_mask_a | r_mask_b) & {NUM_SRC{w_not_full}};

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int s;
            s = int'(r_ptr) + k;
            if (s >= NUM_SRC) s = s - NUM_SRC;
            if (!w_grant_vld && w_elig[s]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = 3'(s);
            end
        end
    end

    assign w_grant_oh = w_grant_vld ? (5'd1 << w_grant_idx) : 5'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= 3'd0;
            r_mask_a <= '0;
            r_mask_b <= '0;
            r_ack    <= '0;
        end else begin
            r_ack    <= w_grant_oh;
            r_mask_a <= w_grant_oh;
            r_mask_b <= r_mask_a;
            if (w_grant_vld)
                r_ptr <= (w_grant_idx == 3'd4) ? 3'd0 : w_grant_idx + 3'd1;
        end
    end

    code_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_grant_vld),
        .i_data  (src_to_code(w_grant_idx)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (w_level)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_level != '0)  w_next_state = PACK;
            PACK:    if (r_cnt == '0)    w_next_state = OFFER;
            OFFER:   if (disp_ready)     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_pop      = (r_state == IDLE) && (w_level != '0);
        packing    = (r_state == PACK);
        disp_valid = (r_state == OFFER);
        disp_code  = (r_state == OFFER) ? r_code : CODE_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= CNT_W'(PACK_CYCLES - 1);
        end else if (r_state == PACK && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) r_code <= w_head;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_box_cnt <= '0;
        else if (r_state == OFFER && disp_ready)
            r_box_cnt <= sat_inc(r_box_cnt);
    end

    assign co_ack     = r_ack;
    assign fifo_level = w_level;
    assign box_cnt    = r_box_cnt;

endmodule

// File: tb/tb_package_dispatcher.sv
// Bench for package_dispatcher: directed scenarios plus random traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_package_dispatcher;

    localparam int DEPTH = 4;
    localparam int PACK  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] co;
    logic       disp_ready;

    logic [4:0] co_ack,  co_ack2;
    logic       packing, packing2;
    logic       disp_valid, disp_valid2;
    logic [2:0] disp_code,  disp_code2;
    logic [2:0] fifo_level, fifo_level2;
    logic [7:0] box_cnt;
    logic [1:0] box_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    package_dispatcher #(.FIFO_DEPTH(DEPTH), .PACK_CYCLES(PACK), .BOX_W(8)) dut (
        .clk(clk), .reset(reset), .co(co), .co_ack(co_ack), .packing(packing),
        .disp_valid(disp_valid), .disp_code(disp_code), .disp_ready(disp_ready),
        .fifo_level(fifo_level), .box_cnt(box_cnt)
    );

    package_dispatcher #(.FIFO_DEPTH(DEPTH), .PACK_CYCLES(PACK), .BOX_W(2)) dut_sat (
        .clk(clk), .reset(reset), .co(co), .co_ack(co_ack2), .packing(packing2),
        .disp_valid(disp_valid2), .disp_code(disp_code2), .disp_ready(disp_ready),
        .fifo_level(fifo_level2), .box_cnt(box_cnt2)
    );

    wire [22:0] dut_vec = {co_ack, packing, disp_valid, disp_code, fifo_level, box_cnt, box_cnt2};

    // Behavioural model: queue of codes, current box with remaining pack time.
    int         q[$];
    int         m_ptr = 0;
    int         m_mask[5] = '{0, 0, 0, 0, 0};
    logic [4:0] m_ack = 5'd0;
    int         m_box = 0;
    int         m_pack_left = 0;
    int         m_boxes = 0;

    task automatic model_edge(input logic rs, input logic [4:0] c, input logic rd);
        int g;
        int lvl;
        if (rs) begin
            q.delete();
            m_ptr = 0;
            for (int k = 0; k < 5; k++) m_mask[k] = 0;
            m_ack = 5'd0;
            m_box = 0;
            m_pack_left = 0;
            m_boxes = 0;
        end else begin
            lvl = q.size();
            g = -1;
            if (lvl < DEPTH) begin
                for (int k = 0; k < 5; k++) begin
                    int i;
                    i = (m_ptr + k) % 5;
                    if (g < 0 && c[i] && m_mask[i] == 0) g = i;
                end
            end
            if (m_box == 0) begin
                if (lvl > 0) begin
                    m_box = q.pop_front();
                    m_pack_left = PACK;
                end
            end else if (m_pack_left > 0) begin
                m_pack_left--;
            end else if (rd) begin
                m_boxes++;
                m_box = 0;
            end
            for (int k = 0; k < 5; k++) if (m_mask[k] > 0) m_mask[k]--;
            m_ack = 5'd0;
            if (g >= 0) begin
                q.push_back(g + 1);
                m_mask[g] = 2;
                m_ack[g] = 1'b1;
                m_ptr = (g + 1) % 5;
            end
        end
    endtask

    function automatic logic [22:0] exp_vec();
        logic       pk, vl;
        logic [2:0] cd;
        int         b1, b2;
        pk = (m_box != 0) && (m_pack_left > 0);
        vl = (m_box != 0) && (m_pack_left == 0);
        cd = vl ? 3'(m_box) : 3'd0;
        b1 = (m_boxes > 255) ? 255 : m_boxes;
        b2 = (m_boxes > 3) ? 3 : m_boxes;
        return {m_ack, pk, vl, cd, 3'(q.size()), 8'(b1), 2'(b2)};
    endfunction

    function automatic int oh_idx(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock: model follows the edge, then counters clear on the ack they
    // saw and any newly full counters raise their flags.
    task automatic step(input logic [4:0] raise);
        logic [4:0] c_s, ack_old;
        logic       rd_s, rs_s;
        c_s = co; rd_s = disp_ready; rs_s = reset; ack_old = m_ack;
        @(posedge clk);
        model_edge(rs_s, c_s, rd_s);
        #1;
        co = (co & ~ack_old) | raise;
    endtask

    task automatic do_reset();
        reset = 1'b1; co = 5'd0; disp_ready = 1'b0;
        step(5'd0);
        step(5'd0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; co = 5'b11111; disp_ready = 1'b1;
        step(5'd0);
        step(5'b11111);
        checks++;
        if (dut_vec !== 23'd0) begin
            errors++;
            $display("FAIL reset_values: got %h, expected %h", dut_vec, 23'd0);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h, expected %h", dut_vec, exp_vec());
        end
        reset = 1'b0; co = 5'd0;
    endtask

    task automatic test_single();
        int ack_cnt = 0, first_ack = -1, pack_cnt = 0, valid_cnt = 0;
        logic [2:0] vcode = 3'd0;
        do_reset();
        disp_ready = 1'b1;
        co = 5'b00100;
        for (int c = 0; c < 14; c++) begin
            step(5'd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL single_cycle %0d: got %h, expected %h", c, dut_vec, exp_vec());
            end
            if (co_ack != 5'd0) begin
                ack_cnt++;
                if (first_ack < 0) first_ack = c;
                checks++;
                if (co_ack !== 5'b00100) begin
                    errors++;
                    $display("FAIL single_ack_value: got %b, expected %b", co_ack, 5'b00100);
                end
            end
            if (packing) pack_cnt++;
            if (disp_valid) begin valid_cnt++; vcode = disp_code; end
        end
        checks++;
        if (ack_cnt !== 1 || first_ack !== 0) begin
            errors++;
            $display("FAIL single_ack_timing: got count %0d at %0d, expected 1 at 0", ack_cnt, first_ack);
        end
        checks++;
        if (pack_cnt !== PACK) begin
            errors++;
            $display("FAIL single_pack_len: got %0d, expected %0d", pack_cnt, PACK);
        end
        checks++;
        if (valid_cnt !== 1 || vcode !== 3'd3) begin
            errors++;
            $display("FAIL single_offer: got %0d cycles code %0d, expected 1 cycle code 3", valid_cnt, vcode);
        end
        checks++;
        if (box_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_box_cnt: got %0d, expected 1", box_cnt);
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int codes[$];
        int exp_g[4] = '{0, 4, 0, 4};
        int exp_c[4] = '{1, 5, 1, 5};
        do_reset();
        disp_ready = 1'b1;
        co = 5'b10001;
        for (int c = 0; c < 90; c++) begin
            step(5'b10001);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rr_cycle %0d: got %h, expected %h", c, dut_vec, exp_vec());
            end
            if (co_ack != 5'd0) grants.push_back(oh_idx(co_ack));
            if (disp_valid && disp_ready) codes.push_back(int'(disp_code));
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grants.size() <= i || grants[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_grant %0d: got %0d, expected %0d", i,
                         (grants.size() > i) ? grants[i] : -1, exp_g[i]);
            end
            checks++;
            if (codes.size() <= i || codes[i] !== exp_c[i]) begin
                errors++;
                $display("FAIL rr_code %0d: got %0d, expected %0d", i,
                         (codes.size() > i) ? codes[i] : -1, exp_c[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        int acks = 0;
        int codes[$];
        do_reset();
        disp_ready = 1'b0;
        co = 5'b11111;
        for (int c = 0; c < 40; c++) begin
            step(5'b11111);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL full_cycle %0d: got %h, expected %h", c, dut_vec, exp_vec());
            end
            if (co_ack != 5'd0) acks++;
        end
        checks++;
        if (acks !== DEPTH + 1 || fifo_level !== 3'(DEPTH) || disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: got acks %0d level %0d valid %b, expected %0d %0d 1",
                     acks, fifo_level, disp_valid, DEPTH + 1, DEPTH);
        end
        co = 5'd0;
        disp_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (disp_valid) codes.push_back(int'(disp_code));
            step(5'd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL drain_cycle %0d: got %h, expected %h", c, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (codes.size() <= i || codes[i] !== i + 1) begin
                errors++;
                $display("FAIL drain_order %0d: got %0d, expected %0d", i,
                         (codes.size() > i) ? codes[i] : -1, i + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        do_reset();
        disp_ready = 1'b0;
        co = 5'b00001;
        while (!disp_valid && guard < 30) begin
            step(5'd0);
            guard++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL bp_wait %0d: got %h, expected %h", guard, dut_vec, exp_vec());
            end
        end
        checks++;
        if (!disp_valid) begin
            errors++;
            $display("FAIL bp_timeout: got valid %b, expected 1 within 30 cycles", disp_valid);
        end
        for (int c = 0; c < 10; c++) begin
            step(5'd0);
            checks++;
            if (disp_valid !== 1'b1 || disp_code !== 3'd1 || box_cnt !== 8'd0) begin
                errors++;
                $display("FAIL bp_hold %0d: got valid %b code %0d box %0d, expected 1 1 0",
                         c, disp_valid, disp_code, box_cnt);
            end
        end
        disp_ready = 1'b1;
        step(5'd0);
        checks++;
        if (box_cnt !== 8'd1 || disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got box %0d valid %b, expected 1 0", box_cnt, disp_valid);
        end
    endtask

    task automatic test_reset_mid_pack();
        do_reset();
        disp_ready = 1'b0;
        co = 5'b00111;
        for (int c = 0; c < 3; c++) begin
            step(5'd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_setup %0d: got %h, expected %h", c, dut_vec, exp_vec());
            end
        end
        checks++;
        if (packing !== 1'b1 || fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL midrst_pre: got packing %b level %0d, expected 1 2", packing, fifo_level);
        end
        reset = 1'b1;
        step(5'd0);
        reset = 1'b0;
        checks++;
        if (packing !== 1'b0 || fifo_level !== 3'd0 || disp_valid !== 1'b0 ||
            box_cnt !== 8'd0 || co_ack !== 5'd0) begin
            errors++;
            $display("FAIL midrst_post: got packing %b level %0d valid %b box %0d ack %b, expected all 0",
                     packing, fifo_level, disp_valid, box_cnt, co_ack);
        end
    endtask

    task automatic test_saturation();
        int guard = 0;
        int prev = 0;
        do_reset();
        disp_ready = 1'b1;
        co = 5'b00001;
        while (m_boxes < 5 && guard < 300) begin
            prev = m_boxes;
            step(5'b00001);
            guard++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sat_cycle %0d: got %h, expected %h", guard, dut_vec, exp_vec());
            end
            if (m_boxes != prev && (m_boxes == 3 || m_boxes == 5)) begin
                checks++;
                if (box_cnt2 !== 2'd3) begin
                    errors++;
                    $display("FAIL sat_value after %0d boxes: got %0d, expected 3", m_boxes, box_cnt2);
                end
            end
        end
        checks++;
        if (box_cnt !== 8'd5) begin
            errors++;
            $display("FAIL sat_wide_cnt: got %0d, expected 5 within 300 cycles", box_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            step(5'($urandom_range(0, 31) & $urandom_range(0, 31)));
            disp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) == 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h, expected %h", c, dut_vec, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        co = 5'd0;
        disp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_backpressure();
        test_reset_mid_pack();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
